smc_loader: RTL and testbench

SMC_LOADER -- requirements
Module: smc_loader

---
 rtl/smc_pkg.sv | 15 +
 rtl/smc_slot_reg.sv | 40 ++++
 rtl/smc_loader.sv | 93 +++++++++
 tb/tb_smc_loader.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/smc_pkg.sv
// Shared constants and state encodings for the SMC frame loader.
package smc_pkg;

    localparam int unsigned NUM_TR  = 6;
    localparam int unsigned FIELD_W = 3;
    localparam int unsigned BUS_W   = NUM_TR * FIELD_W;
    localparam int unsigned CNT_W   = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_LOAD = 2'd1;
    localparam state_t ST_HOLD = 2'd2;

endpackage

// File: rtl/smc_slot_reg.sv
// One transistor slot (W, V_GS, V_DS) with write enable.
// Optional V_GS zero-clamp selected by SMC_LOADER_VGS_CLAMP_EN.
module smc_slot_reg
    import smc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [FIELD_W-1:0] w,
    input  logic [FIELD_W-1:0] v_gs,
    input  logic [FIELD_W-1:0] v_ds,
    output logic [FIELD_W-1:0] q_w,
    output logic [FIELD_W-1:0] q_v_gs,
    output logic [FIELD_W-1:0] q_v_ds
);

    logic [FIELD_W-1:0] v_gs_d;

    always_comb begin
`ifdef SMC_LOADER_VGS_CLAMP_EN
        // Store 0 as 1 so that V_GS-1 downstream never underflows
        v_gs_d = (v_gs == '0) ? FIELD_W'(1) : v_gs;
`else
        v_gs_d = v_gs;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_w    <= '0;
            q_v_gs <= '0;
            q_v_ds <= '0;
        end else if (we) begin
            q_w    <= w;
            q_v_gs <= v_gs_d;
            q_v_ds <= v_ds;
        end
    end

endmodule

// File: rtl/smc_loader.sv
// Collects NUM_TR transistor beats into one frame and holds it until accepted.
// Build option: SMC_LOADER_VGS_CLAMP_EN (V_GS zero-clamp in each slot).
module smc_loader
    import smc_pkg::*;
#(
    parameter int unsigned NUM_TR = smc_pkg::NUM_TR
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             mode,
    input  logic [FIELD_W-1:0]     W,
    input  logic [FIELD_W-1:0]     V_GS,
    input  logic [FIELD_W-1:0]     V_DS,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [1:0]             out_mode,
    output logic [NUM_TR*FIELD_W-1:0] out_W,
    output logic [NUM_TR*FIELD_W-1:0] out_V_GS,
    output logic [NUM_TR*FIELD_W-1:0] out_V_DS
);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic               last_beat;

    // in_ready is a registered copy of (state != HOLD), so accept has no
    // dependence on out_ready and a HOLD-cycle beat is never consumed.
    assign accept    = in_valid && in_ready;
    assign last_beat = (cnt == CNT_W'(NUM_TR - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_mode  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_mode <= mode;
                        cnt      <= CNT_W'(1);
                        state    <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        if (last_beat) begin
                            cnt       <= '0;
                            state     <= ST_HOLD;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_TR; k++) begin : g_slot
        smc_slot_reg u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .we     (accept && (cnt == CNT_W'(k))),
            .w      (W),
            .v_gs   (V_GS),
            .v_ds   (V_DS),
            .q_w    (out_W[k*FIELD_W +: FIELD_W]),
            .q_v_gs (out_V_GS[k*FIELD_W +: FIELD_W]),
            .q_v_ds (out_V_DS[k*FIELD_W +: FIELD_W])
        );
    end

endmodule

// File: tb/tb_smc_loader.sv
// Self-checking bench for smc_loader: directed frames plus random traffic
// against a queue-based frame model.
module tb_smc_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [2:0]  W, V_GS, V_DS;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_mode;
    logic [17:0] out_W, out_V_GS, out_V_DS;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // reference model: beats of the frame being collected, last stored slot contents
    logic [8:0]  beats[$];
    bit          pending;
    logic [1:0]  exp_mode;
    logic [2:0]  exp_w[6], exp_g[6], exp_d[6];

    smc_loader #(.NUM_TR(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .W         (W),
        .V_GS      (V_GS),
        .V_DS      (V_DS),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mode  (out_mode),
        .out_W     (out_W),
        .out_V_GS  (out_V_GS),
        .out_V_DS  (out_V_DS)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [2:0] stored_vgs(input logic [2:0] g);
`ifdef SMC_LOADER_VGS_CLAMP_EN
        return (g == 3'd0) ? 3'd1 : g;
`else
        return g;
`endif
    endfunction

    function automatic logic [17:0] pack(input logic [2:0] f[6]);
        logic [17:0] r = '0;
        for (int k = 0; k < 6; k++) r = r | (18'(f[k]) << (3 * k));
        return r;
    endfunction

    task automatic model_reset();
        beats.delete();
        pending  = 1'b0;
        exp_mode = '0;
        for (int k = 0; k < 6; k++) begin
            exp_w[k] = '0; exp_g[k] = '0; exp_d[k] = '0;
        end
    endtask

    // Applies the handshake rules to the inputs present at the last edge.
    task automatic model_step();
        int slot;
        if (pending) begin
            if (out_ready) pending = 1'b0;
        end else if (in_valid) begin
            slot = beats.size();
            if (slot == 0) exp_mode = mode;
            exp_w[slot] = W;
            exp_g[slot] = stored_vgs(V_GS);
            exp_d[slot] = V_DS;
            beats.push_back({W, V_GS, V_DS});
            if (beats.size() == 6) begin
                pending = 1'b1;
                beats.delete();
            end
        end
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(pending));
        chk("in_ready",  32'(in_ready),  32'(!pending));
        chk("out_mode",  32'(out_mode),  32'(exp_mode));
        chk("out_W",     32'(out_W),     32'(pack(exp_w)));
        chk("out_V_GS",  32'(out_V_GS),  32'(pack(exp_g)));
        chk("out_V_DS",  32'(out_V_DS),  32'(pack(exp_d)));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic beat(input logic [1:0] m, input logic [2:0] w, input logic [2:0] g, input logic [2:0] d);
        in_valid = 1'b1; mode = m; W = w; V_GS = g; V_DS = d;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int budget = 20;
        out_ready = 1'b1;
        while (!out_valid && budget > 0) begin cycle(); budget--; end
        chk("drain_seen_valid", 32'(out_valid), 32'd1);
        cycle();
        out_ready = 1'b0;
    endtask

    int t_first;
    int t_valid;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        mode = '0; W = '0; V_GS = '0; V_DS = '0;
        model_reset();
        #12;
        check_all();
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // back-to-back frame, minimum latency
        t_first = 0;
        for (int k = 0; k < 6; k++) begin
            beat(2'b01, 3'(k + 1), 3'(k + 2), 3'(k));
            if (k < 5) chk("early_valid", 32'(out_valid), 32'd0);
        end
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_W", 32'(out_W), 32'(18'o654321));
        chk("b2b_VGS", 32'(out_V_GS), 32'(18'o765432));
        chk("b2b_VDS", 32'(out_V_DS), 32'(18'o543210));
        chk("b2b_mode", 32'(out_mode), 32'd1);
        drain();

        // 3-cycle gap between beats 2 and 3
        t_valid = 0;
        for (int k = 0; k < 6; k++) begin
            if (k == 2) idle(3);
            beat(2'b01, 3'(k + 1), 3'(k + 2), 3'(k));
            t_valid++;
        end
        t_valid += 3;
        chk("gap_valid", 32'(out_valid), 32'd1);
        chk("gap_cycles", 32'(t_valid), 32'd9);
        chk("gap_W", 32'(out_W), 32'(18'o654321));

        // HOLD with in_valid asserted and no out_ready
        in_valid = 1'b1; mode = 2'b11; W = 3'd7; V_GS = 3'd7; V_DS = 3'd7;
        for (int i = 0; i < 5; i++) cycle();
        chk("hold_in_ready", 32'(in_ready), 32'd0);
        chk("hold_W", 32'(out_W), 32'(18'o654321));
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        chk("hold_release", 32'(out_valid), 32'd0);
        chk("hold_not_consumed", 32'(out_W[2:0]), 32'd1);
        cycle();
        in_valid = 1'b0;
        chk("next_slot0", 32'(out_W[2:0]), 32'd7);
        chk("next_mode", 32'(out_mode), 32'd3);
        for (int k = 1; k < 6; k++) beat(2'b00, 3'(k), 3'(k), 3'(k));
        drain();

        // reset after four beats
        for (int k = 0; k < 4; k++) beat(2'b10, 3'(k + 3), 3'(k + 1), 3'(7 - k));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_W_zero", 32'(out_W), 32'd0);
        #2 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) beat(2'b01, 3'(k + 1), 3'(k + 2), 3'(k));
        chk("post_rst_W", 32'(out_W), 32'(18'o654321));
        drain();

        // V_GS = 0 in slot 3; mode sampled on beat 1 only
        for (int k = 0; k < 6; k++)
            beat((k == 0) ? 2'b10 : 2'b11, 3'd5, (k == 3) ? 3'd0 : 3'd4, 3'd2);
`ifdef SMC_LOADER_VGS_CLAMP_EN
        chk("vgs_slot3", 32'(out_V_GS[11:9]), 32'd1);
`else
        chk("vgs_slot3", 32'(out_V_GS[11:9]), 32'd0);
`endif
        chk("mode_first_beat", 32'(out_mode), 32'd2);
        drain();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            mode = 2'($urandom); W = 3'($urandom); V_GS = 3'($urandom); V_DS = 3'($urandom);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
